// File: rtl/flu_wb_arbiter_pkg.sv
// Shared types and constants for the fixed-latency-unit writeback arbiter.
// Holds the exception record, the buffered entry layout and the source index map.
package flu_wb_arbiter_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [5:0]  cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    localparam int unsigned EX_W = $bits(exception_t);

    // Entry layout as stored in the skid buffers: result on top, exception at the bottom.
    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } flu_wb_entry_t;

    localparam int unsigned FLU_SRC_ALU    = 0;
    localparam int unsigned FLU_SRC_BRANCH = 1;
    localparam int unsigned FLU_SRC_CSR    = 2;
    localparam int unsigned FLU_SRC_MULT   = 3;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned lim);
        return (v + 1 >= lim) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/flu_wb_skid.sv
// Per-source skid FIFO: when empty the incoming result is presented as head (bypass),
// otherwise the oldest buffered entry is. A granted bypass result is never enqueued.
module flu_wb_skid
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         head_valid_o,
    output logic [W-1:0] head_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             enq;
    logic             deq;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign head_valid_o = !empty_o || valid_i;
    assign head_data_o  = empty_o ? data_i : mem_q[rd_ptr_q];

    assign deq = pop_i && !empty_o;
    assign enq = valid_i && !(pop_i && empty_o);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
            if (deq) rd_ptr_q <= PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
            if (enq && !deq) begin
                count_q <= count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/flu_wb_arbiter.sv
// Round-robin multi-port writeback arbiter for the fixed-latency units, one skid FIFO per source.
// Optional stall counters are built when FLU_WB_PERF_EN is defined.
module flu_wb_arbiter
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NR_SRC      = 4,
    parameter int unsigned NR_WB_PORTS = 2,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DATA_W      = XLEN,
    parameter int unsigned TID_W       = TRANS_ID_BITS,
    localparam int unsigned SRC_W      = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NR_SRC-1:0]             src_valid_i,
    output logic [NR_SRC-1:0]             src_ready_o,
    input  logic [NR_SRC*DATA_W-1:0]      src_result_i,
    input  logic [NR_SRC*TID_W-1:0]       src_trans_id_i,
    input  logic [NR_SRC*EX_W-1:0]        src_ex_i,
    output logic [NR_WB_PORTS-1:0]        wb_valid_o,
    output logic [NR_WB_PORTS*DATA_W-1:0] wb_result_o,
    output logic [NR_WB_PORTS*TID_W-1:0]  wb_trans_id_o,
    output logic [NR_WB_PORTS*EX_W-1:0]   wb_ex_o,
    output logic [NR_WB_PORTS*SRC_W-1:0]  wb_src_o,
    output logic                          idle_o
`ifdef FLU_WB_PERF_EN
    ,
    output logic [NR_SRC*32-1:0]          perf_stall_cnt_o
`endif
);

    localparam int unsigned ENT_W = DATA_W + TID_W + EX_W;

    logic [NR_SRC-1:0] push;
    logic [NR_SRC-1:0] head_v;
    logic [NR_SRC-1:0] grant;
    logic [NR_SRC-1:0] full;
    logic [NR_SRC-1:0] empty;
    logic [ENT_W-1:0]  head_d [NR_SRC];
    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  rr_d;

    // Ready and idle come from registered counts only, never from this cycle's valid or grant.
    assign src_ready_o = ~full;
    assign idle_o      = &empty;
    assign push        = src_valid_i & src_ready_o & {NR_SRC{rst_ni & ~flush_i}};

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        logic hv;

        flu_wb_skid #(
            .W     (ENT_W),
            .DEPTH (DEPTH)
        ) u_skid (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .valid_i      (push[s]),
            .pop_i        (grant[s]),
            .data_i       ({src_result_i[s*DATA_W +: DATA_W],
                            src_trans_id_i[s*TID_W +: TID_W],
                            src_ex_i[s*EX_W +: EX_W]}),
            .head_valid_o (hv),
            .head_data_o  (head_d[s]),
            .full_o       (full[s]),
            .empty_o      (empty[s])
        );

        assign head_v[s] = hv & rst_ni & ~flush_i;
    end

    int unsigned idx;
    int unsigned port;
    int unsigned last;
    logic        any;

    // Scan sources from rr_q; the n-th requester found is placed on write port n.
    always_comb begin
        grant         = '0;
        wb_valid_o    = '0;
        wb_result_o   = '0;
        wb_trans_id_o = '0;
        wb_ex_o       = '0;
        wb_src_o      = '0;
        idx           = 0;
        port          = 0;
        last          = 0;
        any           = 1'b0;
        for (int unsigned k = 0; k < NR_SRC; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NR_SRC) idx = idx - NR_SRC;
            if (head_v[idx] && port < NR_WB_PORTS) begin
                grant[idx]                          = 1'b1;
                wb_valid_o[port]                    = 1'b1;
                wb_result_o[port*DATA_W +: DATA_W]  = head_d[idx][ENT_W-1 -: DATA_W];
                wb_trans_id_o[port*TID_W +: TID_W]  = head_d[idx][EX_W +: TID_W];
                wb_ex_o[port*EX_W +: EX_W]          = head_d[idx][EX_W-1:0];
                wb_src_o[port*SRC_W +: SRC_W]       = SRC_W'(idx);
                last                                = idx;
                any                                 = 1'b1;
                port                                = port + 1;
            end
        end
        rr_d = any ? SRC_W'(wrap_inc(last, NR_SRC)) : rr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef FLU_WB_PERF_EN
    logic [31:0] stall_q [NR_SRC];

    // Flush does not clear these; a flushed cycle has no valid heads and so adds nothing.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NR_SRC; s++) begin
            if (!rst_ni) begin
                stall_q[s] <= '0;
            end else if (head_v[s] && !grant[s] && stall_q[s] != '1) begin
                stall_q[s] <= stall_q[s] + 32'd1;
            end
        end
    end

    for (genvar s = 0; s < NR_SRC; s++) begin : g_perf
        assign perf_stall_cnt_o[s*32 +: 32] = stall_q[s];
    end
`endif

    src_protocol_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (src_valid_i & ~src_ready_o) == '0);

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Bench for flu_wb_arbiter: a two-port and a one-port instance, each checked every cycle
// against a queue model, plus directed vectors with literal expectations.
module tb_flu_wb_arbiter;
    import flu_wb_arbiter_pkg::*;

    localparam int MDEPTH = 2;

    typedef struct packed {
        logic [63:0]     res;
        logic [2:0]      tid;
        logic [EX_W-1:0] ex;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;

    logic [3:0]        in_v   [2];
    logic [255:0]      in_res [2];
    logic [11:0]       in_tid [2];
    logic [4*EX_W-1:0] in_ex  [2];

    // two-port instance outputs
    logic [3:0]        d2_rdy;
    logic [1:0]        d2_wb_v;
    logic [127:0]      d2_wb_res;
    logic [5:0]        d2_wb_tid;
    logic [2*EX_W-1:0] d2_wb_ex;
    logic [3:0]        d2_wb_src;
    logic              d2_idle;
    // one-port instance outputs
    logic [3:0]        d1_rdy;
    logic              d1_wb_v;
    logic [63:0]       d1_wb_res;
    logic [2:0]        d1_wb_tid;
    logic [EX_W-1:0]   d1_wb_ex;
    logic [1:0]        d1_wb_src;
    logic              d1_idle;
`ifdef FLU_WB_PERF_EN
    logic [127:0]      d2_perf;
    logic [127:0]      d1_perf;
`endif

    logic [3:0]        o_rdy  [2];
    logic [1:0]        o_v    [2];
    logic [127:0]      o_res  [2];
    logic [5:0]        o_tid  [2];
    logic [2*EX_W-1:0] o_ex   [2];
    logic [3:0]        o_src  [2];
    logic              o_idle [2];
    logic [127:0]      o_perf [2];

    int checks = 0;
    int errors = 0;

    ent_t        mq [2][4][$];
    int          mrr [2];
    logic [31:0] mperf [2][4];

    flu_wb_arbiter #(
        .NR_SRC(4), .NR_WB_PORTS(2), .DEPTH(2), .DATA_W(64), .TID_W(3)
    ) u_dut2 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .src_valid_i    (in_v[0]),
        .src_ready_o    (d2_rdy),
        .src_result_i   (in_res[0]),
        .src_trans_id_i (in_tid[0]),
        .src_ex_i       (in_ex[0]),
        .wb_valid_o     (d2_wb_v),
        .wb_result_o    (d2_wb_res),
        .wb_trans_id_o  (d2_wb_tid),
        .wb_ex_o        (d2_wb_ex),
        .wb_src_o       (d2_wb_src),
        .idle_o         (d2_idle)
`ifdef FLU_WB_PERF_EN
        ,
        .perf_stall_cnt_o (d2_perf)
`endif
    );

    flu_wb_arbiter #(
        .NR_SRC(4), .NR_WB_PORTS(1), .DEPTH(2), .DATA_W(64), .TID_W(3)
    ) u_dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .src_valid_i    (in_v[1]),
        .src_ready_o    (d1_rdy),
        .src_result_i   (in_res[1]),
        .src_trans_id_i (in_tid[1]),
        .src_ex_i       (in_ex[1]),
        .wb_valid_o     (d1_wb_v),
        .wb_result_o    (d1_wb_res),
        .wb_trans_id_o  (d1_wb_tid),
        .wb_ex_o        (d1_wb_ex),
        .wb_src_o       (d1_wb_src),
        .idle_o         (d1_idle)
`ifdef FLU_WB_PERF_EN
        ,
        .perf_stall_cnt_o (d1_perf)
`endif
    );

    always_comb begin
        o_rdy[0]  = d2_rdy;              o_rdy[1]  = d1_rdy;
        o_v[0]    = d2_wb_v;             o_v[1]    = {1'b0, d1_wb_v};
        o_res[0]  = d2_wb_res;           o_res[1]  = {64'd0, d1_wb_res};
        o_tid[0]  = d2_wb_tid;           o_tid[1]  = {3'd0, d1_wb_tid};
        o_ex[0]   = d2_wb_ex;            o_ex[1]   = {{EX_W{1'b0}}, d1_wb_ex};
        o_src[0]  = d2_wb_src;           o_src[1]  = {2'd0, d1_wb_src};
        o_idle[0] = d2_idle;             o_idle[1] = d1_idle;
`ifdef FLU_WB_PERF_EN
        o_perf[0] = d2_perf;             o_perf[1] = d1_perf;
`else
        o_perf[0] = '0;                  o_perf[1] = '0;
`endif
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic clear_all();
        for (int i = 0; i < 2; i++) begin
            in_v[i]   = '0;
            in_res[i] = '0;
            in_tid[i] = '0;
            in_ex[i]  = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_all();
    endtask

    task automatic drive(input int i, input int s, input logic [2:0] tid, input logic [63:0] res);
        in_v[i][s]                 = 1'b1;
        in_tid[i][s*3 +: 3]        = tid;
        in_res[i][s*64 +: 64]      = res;
        in_ex[i][s*EX_W +: EX_W]   = EX_W'({res[7:0], tid, 1'b1});
    endtask

    task automatic reset_pulse();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Model: per-source FIFO queues; heads granted in round-robin order, first n to ports 0..n-1.
    task automatic model_cycle(input int i);
        int   np, port, last, s;
        bit   any;
        bit   all_empty;
        logic [3:0] rdy;
        bit   inc[4], hv[4], gnt[4], was_empty[4];
        ent_t hd[4], inent[4];
        int   gsrc[2];
        np = (i == 0) ? 2 : 1;
        all_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rdy[k]         = (mq[i][k].size() < MDEPTH);
            inent[k].res   = in_res[i][k*64 +: 64];
            inent[k].tid   = in_tid[i][k*3 +: 3];
            inent[k].ex    = in_ex[i][k*EX_W +: EX_W];
            inc[k]         = in_v[i][k] && rdy[k];
            was_empty[k]   = (mq[i][k].size() == 0);
            hd[k]          = was_empty[k] ? inent[k] : mq[i][k][0];
            hv[k]          = rst_n && !flush && (!was_empty[k] || inc[k]);
            gnt[k]         = 1'b0;
            if (!was_empty[k]) all_empty = 1'b0;
        end
        chk($sformatf("d%0d ready", i), 64'(o_rdy[i]), 64'(rdy));
        chk($sformatf("d%0d idle", i), 64'(o_idle[i]), 64'(all_empty));
        port = 0; last = 0; any = 1'b0;
        gsrc[0] = 0; gsrc[1] = 0;
        for (int k = 0; k < 4; k++) begin
            s = (mrr[i] + k) % 4;
            if (hv[s] && port < np) begin
                gnt[s] = 1'b1;
                gsrc[port] = s;
                port++;
                last = s;
                any = 1'b1;
            end
        end
        for (int p = 0; p < np; p++) begin
            if (p < port) begin
                chk($sformatf("d%0d p%0d valid", i, p), 64'(o_v[i][p]), 64'd1);
                chk($sformatf("d%0d p%0d result", i, p), o_res[i][p*64 +: 64], hd[gsrc[p]].res);
                chk($sformatf("d%0d p%0d tid", i, p), 64'(o_tid[i][p*3 +: 3]), 64'(hd[gsrc[p]].tid));
                chk($sformatf("d%0d p%0d ex", i, p), 64'(o_ex[i][p*EX_W +: EX_W]), 64'(hd[gsrc[p]].ex));
                chk($sformatf("d%0d p%0d src", i, p), 64'(o_src[i][p*2 +: 2]), 64'(gsrc[p]));
            end else begin
                chk($sformatf("d%0d p%0d valid", i, p), 64'(o_v[i][p]), 64'd0);
                chk($sformatf("d%0d p%0d idle data", i, p),
                    o_res[i][p*64 +: 64] | 64'(o_tid[i][p*3 +: 3]) | 64'(o_ex[i][p*EX_W +: EX_W])
                    | 64'(o_src[i][p*2 +: 2]), 64'd0);
            end
        end
`ifdef FLU_WB_PERF_EN
        for (int k = 0; k < 4; k++)
            chk($sformatf("d%0d perf%0d", i, k), 64'(o_perf[i][k*32 +: 32]), 64'(mperf[i][k]));
`endif
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) mperf[i][k] = '0;
            else if (hv[k] && !gnt[k] && mperf[i][k] != 32'hffff_ffff) mperf[i][k] = mperf[i][k] + 1;
        end
        if (!rst_n || flush) begin
            for (int k = 0; k < 4; k++) mq[i][k].delete();
            mrr[i] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (gnt[k] && !was_empty[k]) void'(mq[i][k].pop_front());
                if (inc[k] && !(gnt[k] && was_empty[k])) mq[i][k].push_back(inent[k]);
            end
            if (any) mrr[i] = (last + 1) % 4;
        end
    endtask

    // scoreboard / compare process
    initial begin
        mrr[0] = 0;
        mrr[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) mperf[i][k] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle(0);
            model_cycle(1);
        end
    end

    // directed vectors
    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        clear_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("reset wb_valid", 64'(d2_wb_v), 64'd0);
        chk("reset ready", 64'(d2_rdy), 64'hf);
        chk("reset idle", 64'(d2_idle), 64'd1);
        chk("reset data", d2_wb_res[63:0], 64'd0);

        // ALU + MULT together on two ports, then rr back at 0
        step(); drive(0, 0, 3'd1, 64'h11); drive(0, 3, 3'd3, 64'h33);
        @(negedge clk);
        chk("t2 valid", 64'(d2_wb_v), 64'h3);
        chk("t2 p0 result", d2_wb_res[63:0], 64'h11);
        chk("t2 p0 tid", 64'(d2_wb_tid[2:0]), 64'd1);
        chk("t2 p1 tid", 64'(d2_wb_tid[5:3]), 64'd3);
        chk("t2 p1 src", 64'(d2_wb_src[3:2]), 64'd3);
        step(); drive(0, 1, 3'd2, 64'h22); drive(0, 0, 3'd4, 64'h44);
        @(negedge clk);
        chk("t2 rr p0 tid", 64'(d2_wb_tid[2:0]), 64'd4);
        chk("t2 rr p1 tid", 64'(d2_wb_tid[5:3]), 64'd2);

        // all four sources at once
        reset_pulse();
        step();
        for (int s = 0; s < 4; s++) drive(0, s, 3'(s), 64'hA0 + 64'(s));
        @(negedge clk);
        chk("t3 c0 tids", 64'(d2_wb_tid), 64'({3'd1, 3'd0}));
        chk("t3 c0 idle", 64'(d2_idle), 64'd1);
        step();
        @(negedge clk);
        chk("t3 c1 tids", 64'(d2_wb_tid), 64'({3'd3, 3'd2}));
        chk("t3 c1 idle", 64'(d2_idle), 64'd0);
        step();
        @(negedge clk);
        chk("t3 c2 idle", 64'(d2_idle), 64'd1);
        chk("t3 c2 valid", 64'(d2_wb_v), 64'd0);

        // three buffered entries, then flush with a fresh result present
        step();
        for (int s = 0; s < 4; s++) drive(0, s, 3'(s), 64'hB0 + 64'(s));
        step();
        for (int s = 0; s < 3; s++) drive(0, s, 3'(s + 4), 64'hC0 + 64'(s));
        @(negedge clk);
        chk("t5 pre tids", 64'(d2_wb_tid), 64'({3'd3, 3'd2}));
        step(); flush = 1'b1; drive(0, 3, 3'd7, 64'h77);
        @(negedge clk);
        chk("t5 flush valid", 64'(d2_wb_v), 64'd0);
        chk("t5 flush ready", 64'(d2_rdy), 64'hf);
        step(); flush = 1'b0;
        @(negedge clk);
        chk("t5 post idle", 64'(d2_idle), 64'd1);
        chk("t5 post valid", 64'(d2_wb_v), 64'd0);

        // one port, MULT backs up to full while ALU keeps arriving
        step(); drive(1, 0, 3'd0, 64'h10); drive(1, 3, 3'd4, 64'h40);
        @(negedge clk);
        chk("t4 a tid", 64'(d1_wb_tid), 64'd0);
        step(); drive(1, 0, 3'd1, 64'h11); drive(1, 3, 3'd5, 64'h41);
        @(negedge clk);
        chk("t4 b tid", 64'(d1_wb_tid), 64'd4);
        chk("t4 b src", 64'(d1_wb_src), 64'd3);
        step(); drive(1, 0, 3'd2, 64'h12); drive(1, 3, 3'd6, 64'h42);
        @(negedge clk);
        chk("t4 c tid", 64'(d1_wb_tid), 64'd1);
        chk("t4 c ready", 64'(d1_rdy), 64'hf);
        step();
        @(negedge clk);
        chk("t4 d ready", 64'(d1_rdy), 64'h7);
        chk("t4 d tid", 64'(d1_wb_tid), 64'd5);
        step();
        @(negedge clk);
        chk("t4 e tid", 64'(d1_wb_tid), 64'd2);
        step();
        @(negedge clk);
        chk("t4 f tid", 64'(d1_wb_tid), 64'd6);
        chk("t4 f result", d1_wb_res, 64'h42);
        step();
        @(negedge clk);
        chk("t4 g valid", 64'(d1_wb_v), 64'd0);
        chk("t4 g idle", 64'(d1_idle), 64'd1);

        // source 2 waits five cycles in total on the one-port instance
        reset_pulse();
        step();
        for (int s = 0; s < 4; s++) drive(1, s, 3'(s), 64'h60 + 64'(s));
        @(negedge clk); chk("t6 A tid", 64'(d1_wb_tid), 64'd0);
        step(); drive(1, 0, 3'd4, 64'h64);
        @(negedge clk); chk("t6 B tid", 64'(d1_wb_tid), 64'd1);
        step(); drive(1, 2, 3'd5, 64'h65);
        @(negedge clk); chk("t6 C tid", 64'(d1_wb_tid), 64'd2);
        step();
        @(negedge clk); chk("t6 D tid", 64'(d1_wb_tid), 64'd3);
        step(); drive(1, 1, 3'd6, 64'h66);
        @(negedge clk); chk("t6 E tid", 64'(d1_wb_tid), 64'd4);
        step();
        @(negedge clk); chk("t6 F tid", 64'(d1_wb_tid), 64'd6);
        step();
        @(negedge clk); chk("t6 G tid", 64'(d1_wb_tid), 64'd5);
`ifdef FLU_WB_PERF_EN
        chk("t6 perf2", 64'(d1_perf[95:64]), 64'd5);
`endif
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk);
        chk("t6 post idle", 64'(d1_idle), 64'd1);
`ifdef FLU_WB_PERF_EN
        chk("t6 perf2 after flush", 64'(d1_perf[95:64]), 64'd5);
`endif

        repeat (3) step();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
